// File: rtl/exp_align_shift.sv
// FP adder alignment stage: routes the larger-exponent operand to the large path and
// right-shifts the smaller mantissa by the exponent difference into {mant, G, R, S}.
module exp_align_shift #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [MANT_W-1:0]   Mx,
  input  logic [MANT_W-1:0]   My,
  input  logic [EXP_W-1:0]    Ex,
  input  logic [EXP_W-1:0]    Ey,
  input  logic                Sx,
  input  logic                Sy,
  input  logic [EXP_W-1:0]    d,
  input  logic                sgn_d,
  input  logic                zero_d,
  output logic                out_valid,
  output logic [MANT_W-1:0]   M_large,
  output logic [MANT_W+2:0]   M_small_al,
  output logic [EXP_W-1:0]    E_large,
  output logic                S_large,
  output logic                S_small,
  output logic                swapped
);

  localparam int SH_W = MANT_W + 3;
  localparam int LVL  = $clog2(SH_W);

  logic                w_swap;
  logic [MANT_W-1:0]   w_m_large;
  logic [MANT_W-1:0]   w_m_small;
  logic [EXP_W-1:0]    w_e_large;
  logic                w_s_large;
  logic                w_s_small;

  logic                r1_valid;
  logic [MANT_W-1:0]   r1_m_large;
  logic [MANT_W-1:0]   r1_m_small;
  logic [EXP_W-1:0]    r1_e_large;
  logic                r1_s_large;
  logic                r1_s_small;
  logic [EXP_W-1:0]    r1_d;
  logic                r1_swap;

  logic [SH_W-1:0]     w_lvl [0:LVL];
  logic                w_stk [0:LVL];
  logic                w_sat;
  logic [SH_W-1:0]     w_al;

  logic                r2_valid;
  logic [MANT_W-1:0]   r2_m_large;
  logic [SH_W-1:0]     r2_m_small_al;
  logic [EXP_W-1:0]    r2_e_large;
  logic                r2_s_large;
  logic                r2_s_small;
  logic                r2_swap;

  // Operand routing; equal exponents (zero_d) always keep X on the large path.
  always_comb begin
    w_swap    = sgn_d & ~zero_d;
    w_m_large = Mx;
    w_m_small = My;
    w_e_large = Ex;
    w_s_large = Sx;
    w_s_small = Sy;
    if (w_swap) begin
      w_m_large = My;
      w_m_small = Mx;
      w_e_large = Ey;
      w_s_large = Sy;
      w_s_small = Sx;
    end else begin
      w_m_large = Mx;
      w_m_small = My;
      w_e_large = Ex;
      w_s_large = Sx;
      w_s_small = Sy;
    end
  end

  // Stage 1 register: swap decision, shift amount and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_valid   <= 1'b0;
      r1_m_large <= {MANT_W{1'b0}};
      r1_m_small <= {MANT_W{1'b0}};
      r1_e_large <= {EXP_W{1'b0}};
      r1_s_large <= 1'b0;
      r1_s_small <= 1'b0;
      r1_d       <= {EXP_W{1'b0}};
      r1_swap    <= 1'b0;
    end else if (en) begin
      r1_valid   <= in_valid;
      r1_m_large <= w_m_large;
      r1_m_small <= w_m_small;
      r1_e_large <= w_e_large;
      r1_s_large <= w_s_large;
      r1_s_small <= w_s_small;
      r1_d       <= d;
      r1_swap    <= w_swap;
    end
  end

  // Log barrel shifter: each level shifts by 2^k and folds the dropped bits into sticky.
  assign w_lvl[0] = {r1_m_small, 3'b000};
  assign w_stk[0] = 1'b0;

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int SH = 1 << k;
    assign w_lvl[k+1] = r1_d[k] ? {{SH{1'b0}}, w_lvl[k][SH_W-1:SH]} : w_lvl[k];
    assign w_stk[k+1] = w_stk[k] | (r1_d[k] & (|w_lvl[k][SH-1:0]));
  end

  assign w_sat = (r1_d >= EXP_W'(SH_W));

  // Final aligned value; beyond the field width the whole mantissa lands in sticky.
  always_comb begin
    w_al = {SH_W{1'b0}};
    if (w_sat) begin
      w_al = {{(SH_W-1){1'b0}}, |r1_m_small};
    end else begin
      w_al = {w_lvl[LVL][SH_W-1:1], w_lvl[LVL][0] | w_stk[LVL]};
    end
  end

  // Stage 2 register: aligned mantissa plus the large-path fields of the same operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_valid      <= 1'b0;
      r2_m_large    <= {MANT_W{1'b0}};
      r2_m_small_al <= {SH_W{1'b0}};
      r2_e_large    <= {EXP_W{1'b0}};
      r2_s_large    <= 1'b0;
      r2_s_small    <= 1'b0;
      r2_swap       <= 1'b0;
    end else if (en) begin
      r2_valid      <= r1_valid;
      r2_m_large    <= r1_m_large;
      r2_m_small_al <= w_al;
      r2_e_large    <= r1_e_large;
      r2_s_large    <= r1_s_large;
      r2_s_small    <= r1_s_small;
      r2_swap       <= r1_swap;
    end
  end

  assign out_valid  = r2_valid;
  assign M_large    = r2_m_large;
  assign M_small_al = r2_m_small_al;
  assign E_large    = r2_e_large;
  assign S_large    = r2_s_large;
  assign S_small    = r2_s_small;
  assign swapped    = r2_swap;

endmodule

// File: doc/exp_align_shift.md
Name: exp_align_shift

Overview:
- Alignment stage directly downstream of the exponent-difference stage in the pipelined FP adder.
- Consumes the registered exponent difference magnitude, sign and zero flag, plus both operands' signs, exponents and hidden-bit mantissas.
- Swaps operands so the larger-exponent operand is on the "large" path.
- Right-shifts the smaller mantissa by the difference, producing guard/round/sticky bits, through a 2-stage register pipeline with valid tracking and stall.

Parameters:
- MANT_W, 24, mantissa width including hidden bit
- EXP_W, 8, exponent width; also width of the difference input d

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  pipeline advance enable; 0 holds all stage registers
- in_valid  input  1  input operand set valid this cycle
- Mx  input  MANT_W  operand X mantissa with hidden bit
- My  input  MANT_W  operand Y mantissa with hidden bit
- Ex  input  EXP_W  operand X exponent
- Ey  input  EXP_W  operand Y exponent
- Sx  input  1  operand X sign
- Sy  input  1  operand Y sign
- d  input  EXP_W  |Ex-Ey|, aligned in time with the operands
- sgn_d  input  1  1 when Ey > Ex
- zero_d  input  1  1 when d == 0
- out_valid  output  1  outputs valid
- M_large  output  MANT_W  mantissa of the larger-exponent operand
- M_small_al  output  MANT_W+3  shifted smaller mantissa {mant, G, R, S}
- E_large  output  EXP_W  larger exponent (result exponent before normalisation)
- S_large  output  1  sign of the large operand
- S_small  output  1  sign of the small operand
- swapped  output  1  1 when Y was routed to the large path

Behaviour:
- Reset (rst=0, asynchronous): all stage registers and outputs clear to 0, including out_valid. Takes effect immediately, mid-operation included; in-flight data is discarded, not completed.
- Latency: exactly 2 enabled cycles from in_valid sampled to out_valid. Throughput: 1 op per enabled cycle.
- en=0: every register holds, so outputs are stable and no input is sampled. en is not gated by in_valid.
- A bubble (in_valid=0) propagates as out_valid=0. Data registers in a bubble still load (don't-care), so verification checks data only when out_valid=1.
- Stage 1 (register on clk when en=1): swap decision.
  - swap = sgn_d & ~zero_d.
  - If swap: large = (My, Ey, Sy), small = (Mx, Sx). Otherwise large = X, small = Y.
  - Equal exponents never swap.
  - Also registers: d, swap, valid.
- Stage 2 (register on clk when en=1): alignment.
  - Let T = {M_small, 3'b000}, width MANT_W+3.
  - If d < MANT_W+3:
    - M_small_al[MANT_W+2:1] = (T >> d)[MANT_W+2:1].
    - M_small_al[0] = (T >> d)[0] OR (OR of the d low bits of T shifted out).
  - If d >= MANT_W+3: M_small_al = {(MANT_W+2)'b0, |M_small}. The sticky bit carries everything.
  - d = 0 passes T unchanged.
- Large-path fields and signs are delayed identically so all outputs belong to the same operation.
- The shifter is a logarithmic barrel shifter with per-level sticky OR. Variable-width loops are not used.

Test Plan:
- Reset: hold rst=0 with random inputs, then release → all outputs 0 and out_valid=0 until 2 enabled cycles after the first in_valid=1.
- No swap, exact shift: Mx=24'h800000, My=24'hC00000, Ex=8'd130, Ey=8'd129, d=1, sgn_d=0 → 2 cycles later M_large=24'h800000, E_large=130, M_small_al=27'h3000000, swapped=0.
- Swap with sticky: Mx=24'hC00001, My=24'h800000, Ey=Ex+4, d=4, sgn_d=1 → M_large=24'h800000, E_large=Ey, M_small_al=27'h0600001, swapped=1, S_large=Sy.
- Saturation: My=24'h800000, d=30 and again with d=27, sgn_d=0 → M_small_al=27'h0000001 in both cases. My=0, d=30 → M_small_al=0.
- Stall and back-to-back: issue 3 consecutive valid ops, drop en for 2 cycles mid-stream → outputs frozen during the stall. All 3 results emerge in order with correct data and no duplicates.
- Reset mid-operation: assert rst=0 one cycle after an in_valid → out_valid never rises for that op, and all outputs read 0 immediately.
